// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: holds the pipeline while a data-memory req/ready access is outstanding,
// and a hung memory becomes a sticky fault. Optional perf counters: define MEM_STAGE_PERF_EN.
module mem_stage_ctrl #(
    parameter int MAX_WAIT = 15
`ifdef MEM_STAGE_PERF_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic             clk,
    input  logic             R,
    input  logic             MEM_Enable_signal,
    input  logic             MEM_RW_enable,
    input  logic             MEM_Size_enable,
    input  logic             MEM_load_instr,
    input  logic             dm_ready,
    output logic             dm_req,
    output logic             dm_we,
    output logic             dm_size,
    output logic             stall,
    output logic             ld_valid,
    output logic             fault
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0] r_state;
    logic [7:0] r_wait;
    logic       r_ld;
    logic       r_dm_req;
    logic       r_dm_we;
    logic       r_dm_size;
    logic       r_fault;
    logic       w_stall;
    logic       w_accept;

    assign w_accept = (r_state == S_IDLE) && MEM_Enable_signal;

    // Gated by R so the pipeline is never frozen while the core is being reset.
    assign w_stall = !R && (w_accept || (r_state == S_BUSY) || (r_state == S_ERR));

    always_ff @(posedge clk) begin
        if (R) begin
            r_state   <= S_IDLE;
            r_wait    <= 8'd0;
            r_ld      <= 1'b0;
            r_dm_req  <= 1'b0;
            r_dm_we   <= 1'b0;
            r_dm_size <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MEM_Enable_signal) begin
                        r_ld      <= MEM_load_instr;
                        r_dm_req  <= 1'b1;
                        r_dm_we   <= MEM_RW_enable;
                        r_dm_size <= MEM_Size_enable;
                        r_wait    <= 8'd0;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // ready on the final allowed cycle still counts as success
                    if (dm_ready) begin
                        r_dm_req <= 1'b0;
                        r_dm_we  <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (r_wait == WAIT_LAST) begin
                        r_dm_req <= 1'b0;
                        r_dm_we  <= 1'b0;
                        r_fault  <= 1'b1;
                        r_state  <= S_ERR;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dm_req   = r_dm_req;
    assign dm_we    = r_dm_we;
    assign dm_size  = r_dm_size;
    assign stall    = w_stall;
    assign ld_valid = (r_state == S_DONE) && r_ld;
    assign fault    = r_fault;

`ifdef MEM_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (R) begin
            r_acc_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept && !(&r_acc_cnt))
                r_acc_cnt <= r_acc_cnt + CNT_ONE;
            if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign acc_cnt   = r_acc_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: each stimulus cycle queues its hand-computed outputs,
// a negedge monitor pops and compares {dm_req,dm_we,dm_size,stall,ld_valid,fault}.
module tb_mem_stage_ctrl;

    localparam int MW = 5;

    logic clk;
    logic R;
    logic en, rw, sz, ld, rdy;
    logic dm_req, dm_we, dm_size, stall, ld_valid, fault;
`ifdef MEM_STAGE_PERF_EN
    logic [15:0] acc_cnt, stall_cnt;
`endif

    mem_stage_ctrl #(.MAX_WAIT(MW)) dut (
        .clk               (clk),
        .R                 (R),
        .MEM_Enable_signal (en),
        .MEM_RW_enable     (rw),
        .MEM_Size_enable   (sz),
        .MEM_load_instr    (ld),
        .dm_ready          (rdy),
        .dm_req            (dm_req),
        .dm_we             (dm_we),
        .dm_size           (dm_size),
        .stall             (stall),
        .ld_valid          (ld_valid),
        .fault             (fault)
`ifdef MEM_STAGE_PERF_EN
        ,
        .acc_cnt           (acc_cnt),
        .stall_cnt         (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  exp;
        string       name;
        logic        perf_chk;
        logic [15:0] exp_acc;
        logic [15:0] exp_stall;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // one cycle of stimulus plus the outputs expected during that cycle
    task automatic step(input logic r_i, input logic en_i, input logic rw_i, input logic sz_i,
                        input logic ld_i, input logic rdy_i, input logic [5:0] e, input string nm);
        exp_t t;
        @(posedge clk);
        #1;
        R = r_i; en = en_i; rw = rw_i; sz = sz_i; ld = ld_i; rdy = rdy_i;
        t.exp = e; t.name = nm; t.perf_chk = 1'b0; t.exp_acc = '0; t.exp_stall = '0;
        q.push_back(t);
    endtask

    task automatic step_perf(input logic [5:0] e, input string nm,
                             input logic [15:0] a, input logic [15:0] s);
        exp_t t;
        @(posedge clk);
        #1;
        R = 1'b0; en = 1'b0; rw = 1'b0; sz = 1'b0; ld = 1'b0; rdy = 1'b0;
        t.exp = e; t.name = nm; t.perf_chk = 1'b1; t.exp_acc = a; t.exp_stall = s;
        q.push_back(t);
    endtask

    always @(negedge clk) begin
        exp_t       t;
        logic [5:0] act;
        if (q.size() > 0) begin
            t   = q.pop_front();
            act = {dm_req, dm_we, dm_size, stall, ld_valid, fault};
            total++;
            if (act !== t.exp) begin
                bad++;
                $display("FAIL %s: req/we/size/stall/ldv/fault got %b expected %b", t.name, act, t.exp);
            end
`ifdef MEM_STAGE_PERF_EN
            if (t.perf_chk) begin
                total++;
                if (acc_cnt !== t.exp_acc || stall_cnt !== t.exp_stall) begin
                    bad++;
                    $display("FAIL %s_perf: acc=%0d stall_cnt=%0d expected acc=%0d stall_cnt=%0d",
                             t.name, acc_cnt, stall_cnt, t.exp_acc, t.exp_stall);
                end
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        R = 1'b1; en = 1'b0; rw = 1'b0; sz = 1'b0; ld = 1'b0; rdy = 1'b0;

        // reset held with an op pending
        step(1, 1, 0, 0, 1, 0, 6'b000000, "rst_c1");
        step(1, 1, 0, 0, 1, 0, 6'b000000, "rst_c2");
        // word load, ready one cycle after request
        step(0, 1, 0, 0, 1, 0, 6'b000100, "wl_idle");
        step(0, 0, 0, 0, 0, 1, 6'b100100, "wl_busy");
        step(0, 0, 0, 0, 0, 0, 6'b000010, "wl_done");
        step(0, 0, 0, 0, 0, 0, 6'b000000, "wl_idle2");

        // byte store, ready on 4th BUSY cycle; MEM_* noise while busy is ignored
        step(0, 1, 1, 1, 0, 0, 6'b000100, "bs_idle");
        step(0, 1, 0, 0, 1, 0, 6'b111100, "bs_busy1");
        step(0, 1, 0, 0, 1, 0, 6'b111100, "bs_busy2");
        step(0, 0, 0, 0, 0, 0, 6'b111100, "bs_busy3");
        step(0, 0, 0, 0, 0, 1, 6'b111100, "bs_busy4");
        step(0, 0, 0, 0, 0, 0, 6'b001000, "bs_done");
        step(0, 0, 0, 0, 0, 1, 6'b001000, "bs_idle2");

        // timeout: no ready for MW BUSY cycles
        step(0, 1, 0, 0, 1, 0, 6'b001100, "to_idle");
        for (int i = 0; i < MW; i++)
            step(0, 0, 0, 0, 0, 0, 6'b100100, $sformatf("to_busy%0d", i + 1));
        step(0, 1, 0, 0, 1, 1, 6'b000101, "to_err1");
        step(0, 1, 0, 0, 1, 1, 6'b000101, "to_err2");
        step(1, 0, 0, 0, 0, 0, 6'b000001, "to_rst");
        step(0, 0, 0, 0, 0, 0, 6'b000000, "to_clear");

        // ready on exactly the MW-th BUSY cycle wins over timeout
        step(0, 1, 0, 0, 1, 0, 6'b000100, "edge_idle");
        for (int i = 0; i < MW - 1; i++)
            step(0, 0, 0, 0, 0, 0, 6'b100100, $sformatf("edge_busy%0d", i + 1));
        step(0, 0, 0, 0, 0, 1, 6'b100100, "edge_busy_last");
        step(0, 0, 0, 0, 0, 0, 6'b000010, "edge_done");
        step(0, 0, 0, 0, 0, 0, 6'b000000, "edge_idle2");

        // back-to-back loads after a fresh reset, ready immediately
        step(1, 0, 0, 0, 0, 0, 6'b000000, "b2b_rst");
        step(0, 1, 0, 0, 1, 0, 6'b000100, "b2b_idle1");
        step(0, 1, 0, 0, 1, 1, 6'b100100, "b2b_busy1");
        step(0, 1, 0, 0, 1, 0, 6'b000010, "b2b_done1");
        step(0, 1, 0, 0, 1, 0, 6'b000100, "b2b_idle2");
        step(0, 0, 0, 0, 0, 1, 6'b100100, "b2b_busy2");
        step(0, 0, 0, 0, 0, 0, 6'b000010, "b2b_done2");
        step_perf(6'b000000, "b2b_end", 16'd2, 16'd4);

        // reset abandons an access mid-BUSY
        step(0, 1, 0, 0, 1, 0, 6'b000100, "ab_idle");
        step(0, 0, 0, 0, 0, 0, 6'b100100, "ab_busy");
        step(1, 0, 0, 0, 0, 1, 6'b100000, "ab_rst");
        step(0, 0, 0, 0, 0, 1, 6'b000000, "ab_after1");
        step(0, 0, 0, 0, 0, 0, 6'b000000, "ab_after2");

        // no memory ops: pure pass-through regardless of dm_ready
        for (int i = 0; i < 4; i++)
            step(0, 0, i[0], i[1], 1, i[0], 6'b000000, $sformatf("pass%0d", i));

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the MEM stage of the pipelined core. Consumes the MEM-stage control bits latched by the EX/MEM pipeline register and drives a multi-cycle data-memory handshake (req/ready). While an access is outstanding it asserts a global stall that freezes the PC, IF/ID, ID/EX and EX/MEM. A watchdog converts a hung memory into a sticky fault.

## Interface

- MAX_WAIT, 15: maximum BUSY cycles without dm_ready before fault; legal 1..255.
- CNT_W, 16: width of performance counters (only with MEM_STAGE_PERF_EN).

- clk  input  1  pipeline clock; all state changes on rising edge.
- R  input  1  synchronous active-high reset.
- MEM_Enable_signal  input  1  memory op present in MEM stage.
- MEM_RW_enable  input  1  1 = store, 0 = load.
- MEM_Size_enable  input  1  1 = byte, 0 = word.
- MEM_load_instr  input  1  op is a load writing the register file.
- dm_ready  input  1  data memory completes current request this cycle.
- dm_req  output  1  request to data memory (registered).
- dm_we  output  1  write strobe qualifier (registered, latched RW).
- dm_size  output  1  access size (registered, latched Size).
- stall  output  1  freeze PC and IF/ID, ID/EX, EX/MEM (combinational from state/inputs).
- ld_valid  output  1  load data valid for MEM/WB capture (one cycle).
- fault  output  1  sticky memory-timeout flag.
- acc_cnt, stall_cnt  output  CNT_W  perf counters (only with MEM_STAGE_PERF_EN).

## Operation

- States: IDLE, BUSY, DONE, ERR.
- IDLE: dm_req=0. If MEM_Enable_signal=1: latch RW, Size, load_instr; dm_req<=1, dm_we<=RW, dm_size<=Size; wait counter<=0; -> BUSY. stall = MEM_Enable_signal.
- BUSY: stall=1, dm_req=1. If dm_ready=1: dm_req<=0, dm_we<=0 -> DONE. Else if counter==MAX_WAIT-1 -> ERR, fault<=1, dm_req<=0. Else counter+1.
- DONE: stall=0; ld_valid=1 iff latched load_instr=1 (0 for stores). -> IDLE unconditionally; next op (now in EX/MEM) is evaluated in IDLE.
- ERR: stall=1, dm_req=0, fault=1; held until R.
- dm_ready outside BUSY ignored.
- MEM_* inputs ignored while not in IDLE (latched copies used).

## Timing

- Reset (R=1 at edge): state IDLE, dm_req=0, dm_we=0, dm_size=0, ld_valid=0, fault=0, counter=0, perf counters 0; stall=0 once R deasserted unless MEM_Enable_signal=1. Reset mid-access abandons request with dm_req low next cycle.
- Op seen at cycle N (IDLE): dm_req high N+1. dm_ready at N+k (k>=1) -> DONE at N+k+1. stall high N..N+k; low N+k+1.
- Minimum access: 3 cycles (IDLE detect, 1 BUSY, DONE). Back-to-back ops: no overlap; DONE always inserted.
- Timeout: dm_ready absent for MAX_WAIT consecutive BUSY cycles -> ERR on the next edge; dm_ready on exactly the MAX_WAIT-th cycle is success (ready wins over timeout).
- No memory op -> stall=0 permanently; zero-overhead pass-through.

## Configuration

- MEM_STAGE_PERF_EN defined: acc_cnt increments on every IDLE->BUSY; stall_cnt increments every cycle stall=1; both saturate at all-ones, cleared by R.
- Undefined: counters and ports absent; no other behaviour change.

## Test plan

- Reset: R=1 two cycles with MEM_Enable_signal=1 -> all outputs 0, state IDLE; release R -> stall=1 same cycle, dm_req=1 next.
- Word load, dm_ready 1 cycle after req: stall high 2 cycles, dm_we=0, dm_size=0, ld_valid=1 for exactly one cycle.
- Byte store, dm_ready after 4 BUSY cycles: dm_we=1, dm_size=1 throughout BUSY, stall high 5 cycles, ld_valid stays 0.
- MAX_WAIT=3, dm_ready never: ERR after 3 BUSY cycles, fault=1, dm_req=0, stall=1 held; R clears all. Variant: dm_ready on 3rd BUSY cycle -> DONE, fault=0.
- Two back-to-back loads, dm_ready immediate: DONE between them, second dm_req rises 2 cycles after first DONE's IDLE; perf build: acc_cnt=2, stall_cnt=4.
- R asserted during BUSY: dm_req=0 next cycle, no ld_valid, fault=0.
